// File: rtl/reset_seq_if.sv
// reset_seq_if: pipelined Wishbone slave bundle for the reset sequencer.
// Signal names match the SoC bus naming so bridges wire straight through.
interface reset_seq_if;
    logic [1:0]  wb_adr;
    logic [31:0] wb_dat_w;
    logic [31:0] wb_dat_r;
    logic [3:0]  wb_sel;
    logic        wb_cyc;
    logic        wb_stb;
    logic        wb_we;
    logic        wb_ack;
    logic        wb_stall;
    logic        wb_err;

    modport master (
        output wb_adr, wb_dat_w, wb_sel, wb_cyc, wb_stb, wb_we,
        input  wb_dat_r, wb_ack, wb_stall, wb_err
    );

    modport slave (
        input  wb_adr, wb_dat_w, wb_sel, wb_cyc, wb_stb, wb_we,
        output wb_dat_r, wb_ack, wb_stall, wb_err
    );
endinterface

// File: rtl/reset_seq.sv
// reset_seq: staged multi-channel reset sequencer, channel pulses, reset reason.
// Watchdog is compiled in only when RESET_SEQ_WDT_EN is defined.
module reset_seq #(
    parameter int unsigned NUM_CH    = 4,
    parameter int unsigned PULSE_W   = 64,
    parameter int unsigned STAGE_GAP = 16,
    parameter int unsigned WDT_W     = 24
) (
    input  logic              sys_clk,
    input  logic              rst_ni,
    input  logic              ext_reset_i,
    input  logic [NUM_CH-1:0] req_i,
    output logic [NUM_CH-1:0] rst_o,
    output logic              seq_done_o,
    reset_seq_if.slave        wb
);

    localparam int unsigned CntMax = (PULSE_W > STAGE_GAP) ? PULSE_W : STAGE_GAP;
    localparam int unsigned CW = $clog2(CntMax + 1);
    localparam int unsigned PW = $clog2(PULSE_W + 1);
    localparam int unsigned IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    if (NUM_CH < 1 || NUM_CH > 16 || PULSE_W < 1 || STAGE_GAP < 1 ||
        WDT_W < 1 || WDT_W > 32) begin : g_bad_param
        $error("reset_seq: parameter out of range");
    end

    typedef enum logic [1:0] {
        ASSERT_ALL,
        STAGE,
        DONE
    } state_e;

    state_e state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [NUM_CH-1:0] rel_q, rel_d;
    logic done_q, done_d;

    logic trig_q;
    logic [NUM_CH-1:0] preq_q;
    logic [NUM_CH-1:0][PW-1:0] pcnt_q, pcnt_d;
    logic [NUM_CH-1:0] rst_q, rst_d;

    logic [3:0] rsn_q;
    logic [NUM_CH-1:0] rsn_ch_q;
    logic ack_q;
    logic [31:0] dat_q;
    logic [31:0] rd_mux;
    logic [31:0] wdt_rd;
    logic wdt_fire;

    logic acc, wr, rd;
    logic wr_ctrl, rd_rsn, sw_full, full_req;
    logic [NUM_CH-1:0] sw_ch;
    logic unused_bits;

    assign acc     = wb.wb_cyc & wb.wb_stb;
    assign wr      = acc & wb.wb_we;
    assign rd      = acc & ~wb.wb_we;
    assign wr_ctrl = wr & (wb.wb_adr == 2'd0);
    assign rd_rsn  = rd & (wb.wb_adr == 2'd1);
    assign sw_full = wr_ctrl & wb.wb_dat_w[31];
    assign sw_ch   = wr_ctrl ? wb.wb_dat_w[NUM_CH-1:0] : '0;

    // Triggers are registered once so every source shares one latency.
    assign full_req = ext_reset_i | sw_full | wdt_fire;

    assign unused_bits = ^{wb.wb_sel, wb.wb_dat_w};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        rel_d   = rel_q;
        done_d  = done_q;
        if (trig_q) begin
            state_d = ASSERT_ALL;
            cnt_d   = '0;
            idx_d   = '0;
            rel_d   = '0;
            done_d  = 1'b0;
        end else begin
            unique case (state_q)
                ASSERT_ALL: begin
                    if (cnt_q == CW'(PULSE_W - 1)) begin
                        cnt_d    = '0;
                        rel_d[0] = 1'b1;
                        if (NUM_CH == 1) begin
                            state_d = DONE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = STAGE;
                            idx_d   = IW'(1);
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                STAGE: begin
                    if (cnt_q == CW'(STAGE_GAP - 1)) begin
                        cnt_d        = '0;
                        rel_d[idx_q] = 1'b1;
                        if (idx_q == IW'(NUM_CH - 1)) begin
                            state_d = DONE;
                            done_d  = 1'b1;
                        end else begin
                            idx_d = idx_q + IW'(1);
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                DONE: begin
                end
                default: state_d = ASSERT_ALL;
            endcase
        end
    end

    // Unreleased channels ignore pulse requests; a full reset cancels pulses.
    always_comb begin
        pcnt_d = pcnt_q;
        for (int i = 0; i < NUM_CH; i++) begin
            if (trig_q) begin
                pcnt_d[i] = '0;
            end else if (preq_q[i] && rel_q[i]) begin
                pcnt_d[i] = PW'(PULSE_W);
            end else if (pcnt_q[i] != '0) begin
                pcnt_d[i] = pcnt_q[i] - PW'(1);
            end
        end
    end

    always_comb begin
        rst_d = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            rst_d[i] = ~rel_d[i] | (pcnt_d[i] != '0);
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!rst_ni) begin
            state_q <= ASSERT_ALL;
            cnt_q   <= '0;
            idx_q   <= '0;
            rel_q   <= '0;
            done_q  <= 1'b0;
            trig_q  <= 1'b0;
            preq_q  <= '0;
            pcnt_q  <= '0;
            rst_q   <= '1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            rel_q   <= rel_d;
            done_q  <= done_d;
            trig_q  <= full_req;
            preq_q  <= req_i | sw_ch;
            pcnt_q  <= pcnt_d;
            rst_q   <= rst_d;
        end
    end

    assign rst_o      = rst_q;
    assign seq_done_o = done_q;

    // Read clears, but an event landing on the same edge still sets.
    always_ff @(posedge sys_clk) begin
        if (!rst_ni) begin
            rsn_q    <= 4'b0001;
            rsn_ch_q <= '0;
        end else begin
            rsn_q    <= (rd_rsn ? 4'b0000 : rsn_q) |
                        {wdt_fire, sw_full, ext_reset_i, 1'b0};
            rsn_ch_q <= (rd_rsn ? '0 : rsn_ch_q) | req_i | sw_ch;
        end
    end

`ifdef RESET_SEQ_WDT_EN
    logic [WDT_W-1:0] wdt_load_q;
    logic [WDT_W-1:0] wdt_cnt_q;
    logic wdt_arm_q;
    logic wr_load, wr_kick, enter_done;

    assign wr_load    = wr & (wb.wb_adr == 2'd2);
    assign wr_kick    = wr & (wb.wb_adr == 2'd3);
    assign enter_done = (state_d == DONE) && (state_q != DONE);
    assign wdt_fire   = wdt_arm_q && (state_q == DONE) &&
                        (wdt_cnt_q <= WDT_W'(1));
    assign wdt_rd     = 32'(wdt_load_q);

    always_ff @(posedge sys_clk) begin
        if (!rst_ni) begin
            wdt_load_q <= '0;
            wdt_cnt_q  <= '0;
            wdt_arm_q  <= 1'b0;
        end else if (wr_load) begin
            wdt_load_q <= wb.wb_dat_w[WDT_W-1:0];
            wdt_cnt_q  <= wb.wb_dat_w[WDT_W-1:0];
            wdt_arm_q  <= |wb.wb_dat_w[WDT_W-1:0];
        end else if (wr_kick || wdt_fire || enter_done) begin
            wdt_cnt_q <= wdt_load_q;
        end else if (wdt_arm_q && state_q == DONE) begin
            wdt_cnt_q <= wdt_cnt_q - WDT_W'(1);
        end
    end
`else
    assign wdt_fire = 1'b0;
    assign wdt_rd   = '0;
`endif

    always_comb begin
        rd_mux = '0;
        unique case (wb.wb_adr)
            2'd1: rd_mux = {{(24 - NUM_CH){1'b0}}, rsn_ch_q, 4'b0000, rsn_q};
            2'd2: rd_mux = wdt_rd;
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (!rst_ni) begin
            ack_q <= 1'b0;
            dat_q <= '0;
        end else begin
            ack_q <= acc;
            dat_q <= rd ? rd_mux : '0;
        end
    end

    assign wb.wb_ack   = ack_q & wb.wb_cyc;
    assign wb.wb_dat_r = dat_q;
    assign wb.wb_stall = 1'b0;
    assign wb.wb_err   = 1'b0;

endmodule

// File: tb/tb_reset_seq.sv
// tb_reset_seq: directed checks of staged release, pulses, triggers, reason, bus.
// Watchdog scenarios follow RESET_SEQ_WDT_EN like the design.
module tb_reset_seq;
    localparam int PW = 64;
    localparam int SG = 16;

    logic       sys_clk = 1'b0;
    logic       rst_ni;
    logic       ext_reset_i;
    logic [3:0] req_i;
    logic [3:0] rst_o;
    logic       seq_done_o;

    int n_chk = 0;
    int n_fail = 0;

    reset_seq_if bus();

    reset_seq #(
        .NUM_CH(4), .PULSE_W(PW), .STAGE_GAP(SG), .WDT_W(24)
    ) dut (
        .sys_clk(sys_clk),
        .rst_ni(rst_ni),
        .ext_reset_i(ext_reset_i),
        .req_i(req_i),
        .rst_o(rst_o),
        .seq_done_o(seq_done_o),
        .wb(bus)
    );

    always #5 sys_clk = ~sys_clk;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge sys_clk);
            #1;
        end
    endtask

    task automatic wb_write(input logic [1:0] a, input logic [31:0] d);
        bus.wb_cyc = 1'b1; bus.wb_stb = 1'b1; bus.wb_we = 1'b1;
        bus.wb_adr = a; bus.wb_dat_w = d;
        tick(1);
        bus.wb_cyc = 1'b0; bus.wb_stb = 1'b0; bus.wb_we = 1'b0;
    endtask

    task automatic wb_read(input logic [1:0] a, output logic [31:0] d);
        bus.wb_cyc = 1'b1; bus.wb_stb = 1'b1; bus.wb_we = 1'b0;
        bus.wb_adr = a;
        tick(1);
        d = bus.wb_dat_r;
        bus.wb_cyc = 1'b0; bus.wb_stb = 1'b0;
    endtask

    task automatic test_reset();
        int fall[4];
        int done_k;
        logic [31:0] d;
        rst_ni = 1'b0;
        tick(5);
        n_chk++; if (rst_o !== 4'hF) begin n_fail++; $display("FAIL por_rst_o: got %h expected f", rst_o); end
        n_chk++; if (seq_done_o !== 1'b0) begin n_fail++; $display("FAIL por_done: got %b expected 0", seq_done_o); end
        n_chk++; if (bus.wb_ack !== 1'b0) begin n_fail++; $display("FAIL por_ack: got %b expected 0", bus.wb_ack); end
        n_chk++; if (bus.wb_dat_r !== 32'h0) begin n_fail++; $display("FAIL por_dat_r: got %h expected 0", bus.wb_dat_r); end
        rst_ni = 1'b1;
        for (int i = 0; i < 4; i++) fall[i] = -1;
        done_k = -1;
        for (int k = 1; k <= 130; k++) begin
            tick(1);
            for (int i = 0; i < 4; i++)
                if (fall[i] < 0 && rst_o[i] === 1'b0) fall[i] = k;
            if (done_k < 0 && seq_done_o === 1'b1) done_k = k;
        end
        for (int i = 0; i < 4; i++) begin
            n_chk++;
            if (fall[i] !== PW + i * SG) begin
                n_fail++;
                $display("FAIL por_fall%0d: got %0d expected %0d", i, fall[i], PW + i * SG);
            end
        end
        n_chk++; if (done_k !== PW + 3 * SG) begin n_fail++; $display("FAIL por_done_k: got %0d expected %0d", done_k, PW + 3 * SG); end
        wb_read(2'd1, d);
        n_chk++; if (d !== 32'h1) begin n_fail++; $display("FAIL por_reason: got %h expected 1", d); end
        wb_read(2'd1, d);
        n_chk++; if (d !== 32'h0) begin n_fail++; $display("FAIL por_reason_clr: got %h expected 0", d); end
    endtask

    task automatic test_ctrl_pulse();
        int first, cnt;
        logic others;
        logic [31:0] d;
        wb_write(2'd0, 32'h4);
        n_chk++; if (rst_o !== 4'h0) begin n_fail++; $display("FAIL ctrl_lat0: got %h expected 0", rst_o); end
        first = -1; cnt = 0; others = 1'b0;
        for (int k = 1; k <= 70; k++) begin
            tick(1);
            if (rst_o[2] === 1'b1) begin
                cnt++;
                if (first < 0) first = k;
            end
            if ((rst_o & 4'hB) !== 4'h0) others = 1'b1;
        end
        n_chk++; if (first !== 1) begin n_fail++; $display("FAIL ctrl_first: got %0d expected 1", first); end
        n_chk++; if (cnt !== PW) begin n_fail++; $display("FAIL ctrl_width: got %0d expected %0d", cnt, PW); end
        n_chk++; if (others !== 1'b0) begin n_fail++; $display("FAIL ctrl_others: got %b expected 0", others); end
        wb_read(2'd1, d);
        n_chk++; if (d !== 32'h400) begin n_fail++; $display("FAIL ctrl_reason: got %h expected 400", d); end
    endtask

    task automatic test_req_retrigger();
        int first, last;
        req_i = 4'h2;
        tick(1);
        req_i = 4'h0;
        first = -1; last = -1;
        for (int k = 1; k <= 120; k++) begin
            req_i = (k == 30) ? 4'h2 : 4'h0;
            tick(1);
            if (rst_o[1] === 1'b1) begin
                if (first < 0) first = k;
                last = k;
            end
        end
        req_i = 4'h0;
        n_chk++; if (first !== 1) begin n_fail++; $display("FAIL req_first: got %0d expected 1", first); end
        n_chk++; if (last !== 30 + PW) begin n_fail++; $display("FAIL req_last: got %0d expected %0d", last, 30 + PW); end
    endtask

    task automatic test_seq_restart();
        int f0, dk;
        logic seen;
        logic [31:0] d;
        wb_write(2'd0, 32'h8000_0000);
        tick(1);
        n_chk++; if (rst_o !== 4'hF) begin n_fail++; $display("FAIL sw_full_lat: got %h expected f", rst_o); end
        seen = 1'b0;
        for (int k = 0; k < 200 && !seen; k++) begin
            tick(1);
            if (rst_o[1] === 1'b0) seen = 1'b1;
        end
        n_chk++; if (seen !== 1'b1 || rst_o !== 4'hC) begin n_fail++; $display("FAIL stage2: got %h expected c", rst_o); end
        wb_write(2'd0, 32'h8000_0000);
        tick(1);
        n_chk++; if (rst_o !== 4'hF || seq_done_o !== 1'b0) begin n_fail++; $display("FAIL restart: got %h/%b expected f/0", rst_o, seq_done_o); end
        f0 = -1; dk = -1;
        for (int k = 1; k <= 130; k++) begin
            tick(1);
            if (f0 < 0 && rst_o[0] === 1'b0) f0 = k;
            if (dk < 0 && seq_done_o === 1'b1) dk = k;
        end
        n_chk++; if (f0 !== PW) begin n_fail++; $display("FAIL restart_f0: got %0d expected %0d", f0, PW); end
        n_chk++; if (dk !== PW + 3 * SG) begin n_fail++; $display("FAIL restart_done: got %0d expected %0d", dk, PW + 3 * SG); end
        wb_read(2'd1, d);
        n_chk++; if (d !== 32'h204) begin n_fail++; $display("FAIL restart_reason: got %h expected 204", d); end
    endtask

    task automatic test_ext();
        int f0, dk;
        logic [31:0] d;
        ext_reset_i = 1'b1;
        bus.wb_cyc = 1'b1; bus.wb_stb = 1'b1; bus.wb_we = 1'b0; bus.wb_adr = 2'd1;
        tick(1);
        d = bus.wb_dat_r;
        bus.wb_cyc = 1'b0; bus.wb_stb = 1'b0;
        n_chk++; if (d !== 32'h0) begin n_fail++; $display("FAIL ext_coinc_read: got %h expected 0", d); end
        tick(1);
        n_chk++; if (rst_o !== 4'hF || seq_done_o !== 1'b0) begin n_fail++; $display("FAIL ext_lat: got %h/%b expected f/0", rst_o, seq_done_o); end
        tick(8);
        ext_reset_i = 1'b0;
        f0 = -1; dk = -1;
        for (int k = 1; k <= 130; k++) begin
            tick(1);
            if (f0 < 0 && rst_o[0] === 1'b0) f0 = k;
            if (dk < 0 && seq_done_o === 1'b1) dk = k;
        end
        n_chk++; if (f0 !== PW + 1) begin n_fail++; $display("FAIL ext_f0: got %0d expected %0d", f0, PW + 1); end
        n_chk++; if (dk !== PW + 1 + 3 * SG) begin n_fail++; $display("FAIL ext_done: got %0d expected %0d", dk, PW + 1 + 3 * SG); end
        wb_read(2'd1, d);
        n_chk++; if (d !== 32'h2) begin n_fail++; $display("FAIL ext_reason: got %h expected 2", d); end
    endtask

    task automatic test_unreleased();
        int f3;
        logic rerise;
        logic [31:0] d;
        wb_write(2'd0, 32'h8000_0000);
        tick(1);
        f3 = -1; rerise = 1'b0;
        for (int k = 1; k <= 180; k++) begin
            req_i = (k == 100) ? 4'h8 : 4'h0;
            tick(1);
            if (f3 < 0 && rst_o[3] === 1'b0) f3 = k;
            if (f3 >= 0 && rst_o[3] === 1'b1) rerise = 1'b1;
        end
        req_i = 4'h0;
        n_chk++; if (f3 !== PW + 3 * SG) begin n_fail++; $display("FAIL unrel_f3: got %0d expected %0d", f3, PW + 3 * SG); end
        n_chk++; if (rerise !== 1'b0) begin n_fail++; $display("FAIL unrel_rerise: got %b expected 0", rerise); end
        wb_read(2'd1, d);
        n_chk++; if (d !== 32'h804) begin n_fail++; $display("FAIL unrel_reason: got %h expected 804", d); end
    endtask

    task automatic test_back_to_back();
        logic a1, a2, a3, st, er;
        logic [31:0] d1, d2;
        wb_write(2'd0, 32'h1);
        bus.wb_cyc = 1'b1; bus.wb_stb = 1'b1; bus.wb_we = 1'b0; bus.wb_adr = 2'd1;
        tick(1);
        a1 = bus.wb_ack; d1 = bus.wb_dat_r;
        st = bus.wb_stall; er = bus.wb_err;
        bus.wb_adr = 2'd2;
        tick(1);
        a2 = bus.wb_ack; d2 = bus.wb_dat_r;
        st = st | bus.wb_stall; er = er | bus.wb_err;
        bus.wb_stb = 1'b0;
        tick(1);
        a3 = bus.wb_ack;
        bus.wb_cyc = 1'b0;
        n_chk++; if (a1 !== 1'b1 || a2 !== 1'b1) begin n_fail++; $display("FAIL b2b_ack: got %b%b expected 11", a1, a2); end
        n_chk++; if (d1 !== 32'h100) begin n_fail++; $display("FAIL b2b_reason: got %h expected 100", d1); end
        n_chk++; if (d2 !== 32'h0) begin n_fail++; $display("FAIL b2b_wdt_load: got %h expected 0", d2); end
        n_chk++; if (st !== 1'b0 || er !== 1'b0) begin n_fail++; $display("FAIL b2b_stall_err: got %b%b expected 00", st, er); end
        n_chk++; if (a3 !== 1'b0) begin n_fail++; $display("FAIL b2b_ack_idle: got %b expected 0", a3); end
    endtask

`ifdef RESET_SEQ_WDT_EN
    task automatic test_wdt();
        int fk;
        logic seen, bad;
        logic [31:0] d;
        tick(70);
        wb_write(2'd2, 32'd100);
        fk = -1;
        for (int k = 1; k <= 150 && fk < 0; k++) begin
            tick(1);
            if (rst_o === 4'hF) fk = k;
        end
        n_chk++; if (fk !== 101) begin n_fail++; $display("FAIL wdt_fire: got %0d expected 101", fk); end
        seen = 1'b0;
        for (int k = 0; k < 200 && !seen; k++) begin
            tick(1);
            if (seq_done_o === 1'b1) seen = 1'b1;
        end
        wb_read(2'd1, d);
        n_chk++; if (seen !== 1'b1 || d !== 32'h8) begin n_fail++; $display("FAIL wdt_reason: got %h expected 8", d); end
        wb_read(2'd2, d);
        n_chk++; if (d !== 32'd100) begin n_fail++; $display("FAIL wdt_load_rd: got %0d expected 100", d); end
        bad = 1'b0;
        for (int j = 0; j < 20; j++) begin
            wb_write(2'd3, 32'h0);
            for (int k = 0; k < 49; k++) begin
                tick(1);
                if (rst_o !== 4'h0 || seq_done_o !== 1'b1) bad = 1'b1;
            end
        end
        n_chk++; if (bad !== 1'b0) begin n_fail++; $display("FAIL wdt_kick: got %b expected 0", bad); end
        wb_write(2'd2, 32'h0);
    endtask
`else
    task automatic test_wdt();
        logic bad;
        logic [31:0] d;
        tick(70);
        wb_write(2'd2, 32'd100);
        wb_read(2'd2, d);
        n_chk++; if (d !== 32'h0) begin n_fail++; $display("FAIL nowdt_load_rd: got %h expected 0", d); end
        bad = 1'b0;
        for (int k = 0; k < 150; k++) begin
            tick(1);
            if (rst_o !== 4'h0) bad = 1'b1;
        end
        n_chk++; if (bad !== 1'b0) begin n_fail++; $display("FAIL nowdt_quiet: got %b expected 0", bad); end
        wb_read(2'd1, d);
        n_chk++; if (d !== 32'h0) begin n_fail++; $display("FAIL nowdt_reason: got %h expected 0", d); end
    endtask
`endif

    initial begin
        rst_ni = 1'b0;
        ext_reset_i = 1'b0;
        req_i = 4'h0;
        bus.wb_adr = 2'd0;
        bus.wb_dat_w = 32'h0;
        bus.wb_sel = 4'hF;
        bus.wb_cyc = 1'b0;
        bus.wb_stb = 1'b0;
        bus.wb_we = 1'b0;
        test_reset();
        test_ctrl_pulse();
        test_req_retrigger();
        test_seq_restart();
        test_ext();
        test_unreleased();
        test_back_to_back();
        test_wdt();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
